led_fade_driver: RTL
====================

// Module: led_fade_driver
// PURPOSE
//   Sits directly downstream of the 8-bit LED PIO output register and drives the board LEDs.
//   On each change of the PIO pattern, every LED ramps its brightness linearly toward on or off.
//   Brightness is produced by PWM. Software writes only the on/off pattern.
//   When enable is low, the ramp is bypassed and the LEDs follow the pattern hard on/off.
// PARAMETERS
//   N_LEDS    8     number of LED channels (width of pattern_in / led_out)
//   PWM_BITS  8     brightness resolution; MAXL = 2**PWM_BITS-1 (255)
//   STEP_DIV  50000 clk cycles per brightness step (>=1); full ramp = MAXL*STEP_DIV cycles
// PORTS
//   clk         in   1       system clock
//   reset_n     in   1       reset, asynchronous, active-low
//   pattern_in  in   N_LEDS  target on/off pattern from LED PIO out_port (same clk domain)
//   enable      in   1       1 = fading active, 0 = bypass (hard on/off)
//   led_out     out  N_LEDS  PWM-modulated LED drive, registered
//   busy        out  1       1 while any channel level != its target
// BEHAVIOUR
//   Reset (async, reset_n=0)
//     - pattern_q, level[i], pwm_cnt, step_cnt and led_out all clear to 0; busy=0.
//     - Asserting reset mid-ramp forces led_out=0 immediately, without waiting for clk.
//     - The block resumes from all-off after release.
//   Input stage
//     - pattern_q <= pattern_in every clk; 1-cycle register, no CDC logic.
//     - target[i] = pattern_q[i] ? MAXL : 0.
//   PWM counter
//     - pwm_cnt counts 0..MAXL-1 and wraps to 0; period = MAXL clocks; free-running at all times.
//   Step prescaler
//     - step_cnt counts 0..STEP_DIV-1 and wraps; tick=1 on the cycle step_cnt==STEP_DIV-1.
//     - STEP_DIV=1 gives tick every cycle.
//     - Held at 0 while enable=0.
//   Level update, per channel, each clk
//     - enable=0: level[i] <= target[i].
//     - enable=1 and tick: level moves 1 toward target (+1 if level<target, -1 if level>target).
//     - enable=1 and no tick: level holds.
//     - Arithmetic is PWM_BITS-wide unsigned; the move never overshoots, so no wrap is possible.
//     - Target change mid-ramp reverses direction from the current level; no jump.
//     - A pattern change coincident with tick uses the new target on the next tick.
//     - The current tick uses target as seen that cycle (pattern_q).
//   Output
//     - led_out[i] <= (level[i] > pwm_cnt).
//     - Level 0 = constant 0; level MAXL = constant 1; level L = exactly L high cycles per MAXL-cycle period.
//     - A level update coinciding with pwm_cnt wrap takes effect on the compare in the next cycle;
//       a period may therefore mix two levels. This is accepted.
//   busy
//     - Combinational: OR over i of (level[i] != target[i]).
//     - In bypass it pulses high for exactly 1 cycle after a pattern_q change.
//   Latency
//     - Bypass: pattern_in to led_out is 3 clk (pattern_q, level, led_out).
//     - Fading: first level step at the next tick after pattern_q updates.
//   Enable toggling
//     - 1->0: levels snap to target next cycle.
//     - 0->1: step_cnt starts from 0; levels already equal target, so there is no visible change.
// TESTING (bench uses PWM_BITS=8, STEP_DIV=4)
//   1. Reset: hold reset_n=0 with pattern_in=0xFF, enable=1 -> led_out=0x00, busy=0. Release: no change until ticks accrue.
//   2. Bypass: enable=0, pattern_in 0x00->0xA5 -> led_out=0xA5 exactly 3 clk later; busy high for 1 cycle only.
//   3. Ramp up: enable=1, pattern 0x00->0x01 -> level[0] +1 every 4 clk.
//      Reaches 255 after 1020 clk, then busy falls and led_out[0] is constant 1.
//      At level 128, led_out[0] is high 128 of 255 clk.
//   4. Reversal: during ramp at level[0]=100 set pattern_in=0x00 -> next tick level=99, then descends to 0.
//      busy deasserts when level=0; no jump in duty.
//   5. Async reset mid-ramp: pulse reset_n low between clk edges at level 150 -> led_out=0 before the next edge.
//      All state is 0 after release.
//   6. Multi-channel/edge: pattern 0x0F->0xF0 mid-ramp with STEP_DIV=1.
//      Channels 0-3 fall and 4-7 rise independently, each 1/cycle.
//      No level passes 0 or 255, and no wrap occurs.

Source files
------------

// File: rtl/led_fade_driver.sv
// led_fade_driver
//   Drives the board LEDs from the LED PIO on/off pattern. Each channel ramps
//   its brightness linearly toward fully on or fully off, one step per
//   prescaler tick, and the brightness is rendered as PWM. When enable is low
//   the ramp is bypassed and each level snaps straight to its target.
module led_fade_driver #(
  parameter int N_LEDS   = 8,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_LEDS-1:0] pattern_in,
  input  logic              enable,
  output logic [N_LEDS-1:0] led_out,
  output logic              busy
);

  // STEP_DIV=1 still needs a 1-bit counter; it simply never leaves 0.
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PWM_BITS-1:0] MAXL      = '1;
  localparam logic [PWM_BITS-1:0] PWM_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] PWM_ONE   = {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [SW-1:0]       STEP_ONE  = SW'(1);

  logic [N_LEDS-1:0]                r_pattern_q;
  logic [N_LEDS-1:0][PWM_BITS-1:0]  r_level;
  logic [PWM_BITS-1:0]              r_pwm_cnt;
  logic [SW-1:0]                    r_step_cnt;

  logic                             w_tick;
  logic [N_LEDS-1:0][PWM_BITS-1:0]  w_target;
  logic [N_LEDS-1:0]                w_diff;

  assign w_tick = (r_step_cnt == STEP_LAST);

  // Targets are always one of the two rails, so a level can only ever move
  // toward a rail and stop there; no wrap is reachable.
  always_comb begin
    w_target = '0;
    w_diff   = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      w_target[i] = r_pattern_q[i] ? MAXL : '0;
      w_diff[i]   = (r_level[i] != w_target[i]);
    end
  end

  assign busy = |w_diff;

  // Single register stage on the PIO pattern (same clock domain, no CDC).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_pattern_q <= '0;
    else          r_pattern_q <= pattern_in;
  end

  // Free-running PWM phase, period MAXL clocks (0..MAXL-1).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    r_pwm_cnt <= '0;
    else if (r_pwm_cnt == PWM_LAST)  r_pwm_cnt <= '0;
    else                             r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
  end

  // Step prescaler; parked at 0 in bypass so a re-enable starts a full interval.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_step_cnt <= '0;
    else if (!enable) r_step_cnt <= '0;
    else if (w_tick)  r_step_cnt <= '0;
    else              r_step_cnt <= r_step_cnt + STEP_ONE;
  end

  // Per-channel brightness: snap in bypass, otherwise one step toward target per tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
    end else begin
      for (int i = 0; i < N_LEDS; i++) begin
        if (!enable) begin
          r_level[i] <= w_target[i];
        end else if (w_tick) begin
          if (r_pattern_q[i] && (r_level[i] != MAXL))
            r_level[i] <= r_level[i] + PWM_ONE;
          else if (!r_pattern_q[i] && (r_level[i] != '0))
            r_level[i] <= r_level[i] - PWM_ONE;
        end
      end
    end
  end

  // PWM compare: level L gives exactly L high cycles per MAXL-cycle period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= '0;
    end else begin
      for (int i = 0; i < N_LEDS; i++)
        led_out[i] <= (r_level[i] > r_pwm_cnt);
    end
  end

endmodule
